cosim_step_sched: RTL and testbench
===================================

COSIM_STEP_SCHED -- requirements
Module: cosim_step_sched

Interface
REQ-001 SHALL have parameter NumHarts, default 2, meaning number of DUT commit streams (1..8).
REQ-002 SHALL have parameter FifoDepth, default 4, meaning per-hart commit buffer entries (power of 2, >=2).
REQ-003 SHALL have parameter XLen, default 64, meaning PC/data width (equals XREG_W).
REQ-004 SHALL have port clk_i, input, 1, meaning single clock; all logic rising-edge.
REQ-005 SHALL have port rst_i, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port commit_valid_i, input, NumHarts, meaning per-hart DUT retire valid.
REQ-007 SHALL have port commit_ready_o, output, NumHarts, meaning per-hart buffer accept.
REQ-008 SHALL have ports commit_pc_i, commit_rd_we_i, commit_rd_i and commit_wdata_i, all inputs, with widths NumHarts*XLen, NumHarts, NumHarts*5 and NumHarts*XLen, meaning retired PC and rd write.
REQ-009 SHALL have port step_req_o, output, 1, meaning request one reference-model step.
REQ-010 SHALL have port step_hart_o, output, $clog2(NumHarts) (min 1), meaning processor_id of requested step.
REQ-011 SHALL have port step_ack_i, input, 1, meaning step done and ref_* valid this cycle.
REQ-012 SHALL have ports ref_pc_i, ref_rd_we_i, ref_rd_i and ref_wdata_i, all inputs, with widths XLen, 1, 5 and XLen, meaning reference PC and rd write.
REQ-013 SHALL have port sim_done_i, input, 1, meaning reference reported exit code.
REQ-014 SHALL have ports mismatch_o (1) and mismatch_kind_o (2), both outputs, meaning compare result pulse and kind (01 PC, 10 reg, 11 both).
REQ-015 SHALL have port mismatch_hart_o, output, width of step_hart_o, meaning hart of the mismatch.
REQ-016 SHALL have port checked_cnt_o, output, 32, meaning total compared commits.
REQ-017 SHALL have port halt_o, output, 1, meaning sticky stop.

Function
REQ-018 SHALL hold one FIFO per hart; push when commit_valid_i & commit_ready_o; commit_ready_o = !full & !halt_o (no full-bypass).
REQ-019 SHALL run FSM IDLE -> STEP -> CMP -> IDLE, plus HALT.
REQ-020 IDLE SHALL grant, by round-robin starting at the hart after the last grant, the first hart whose FIFO is non-empty; a pushed entry is grantable the cycle after its push.
REQ-021 On grant SHALL enter STEP next cycle with step_req_o=1 and step_hart_o=granted hart, both held stable until step_ack_i.
REQ-022 step_ack_i in STEP SHALL capture ref_* that cycle, deassert step_req_o next cycle, and enter CMP.
REQ-023 step_ack_i outside STEP SHALL be ignored.
REQ-024 CMP (one cycle) SHALL pop the head entry of the granted hart.
REQ-025 CMP SHALL set PC mismatch if pc differs.
REQ-026 CMP SHALL set reg mismatch if effective we differs, or if both write and rd or wdata differ; effective we = rd_we & (rd != 0).
REQ-027 CMP SHALL pulse mismatch_o for exactly that cycle when any mismatch, with mismatch_kind_o and mismatch_hart_o valid only while mismatch_o=1 and 0 otherwise.
REQ-028 CMP SHALL increment checked_cnt_o, saturating at 0xFFFFFFFF.
REQ-029 From CMP, a mismatch or sim_done_i SHALL go to HALT; otherwise to IDLE.
REQ-030 sim_done_i in IDLE SHALL go to HALT; in STEP it SHALL take effect after CMP.
REQ-031 HALT SHALL hold halt_o=1, commit_ready_o=0 and step_req_o=0 until reset, with FIFO contents frozen.
REQ-032 Simultaneous push to and pop from the same FIFO in CMP SHALL both take effect (pointer wrap modulo FifoDepth).

Reset
REQ-033 rst_i SHALL, at any state including mid-STEP, next cycle force IDLE, empty all FIFOs and set round-robin pointer to hart 0.
REQ-034 Under rst_i, outputs step_req_o=0, step_hart_o=0, mismatch_o=0, mismatch_kind_o=0, mismatch_hart_o=0, checked_cnt_o=0 and halt_o=0.
REQ-035 commit_ready_o SHALL be 0 while rst_i=1 and all 1 the cycle after release.

Verification
REQ-036 Single hart: push pc=0x80000000, rd=5, we=1, wdata=0x1234; ack same values -> step_req_o 1 cycle after push accept, no mismatch, checked_cnt_o=1.
REQ-037 Both harts have entries after last grant=1 -> grant order hart0, hart1, hart0 ...; step_hart_o stable while ack delayed 3 cycles.
REQ-038 ref_pc_i=0x80000004 vs DUT 0x80000000 with wdata also different -> mismatch_o pulse, kind=11, halt_o=1, commit_ready_o=0.
REQ-039 DUT we=1, rd=0 vs ref we=0 -> no mismatch.
REQ-040 Fill FifoDepth=4 with no ack -> commit_ready_o=0 at 4 entries; push during CMP accepted next cycle; wrap after 5+ entries.
REQ-041 rst_i asserted while step_req_o=1 -> next cycle step_req_o=0, FIFOs empty, checked_cnt_o=0; late ack ignored.

Source files
------------

// File: rtl/cosim_step_sched_if.sv
// Commit-stream and reference-model step handshake bundle for cosim_step_sched.
// slave faces the scheduler, master faces the commit source / reference model.
interface cosim_step_sched_if #(
   parameter int unsigned NumHarts = 2,
   parameter int unsigned XLen     = 64
);
   localparam int unsigned HartW = (NumHarts > 1) ? $clog2(NumHarts) : 1;

   logic [NumHarts-1:0]      commit_valid_i;
   logic [NumHarts-1:0]      commit_ready_o;
   logic [NumHarts*XLen-1:0] commit_pc_i;
   logic [NumHarts-1:0]      commit_rd_we_i;
   logic [NumHarts*5-1:0]    commit_rd_i;
   logic [NumHarts*XLen-1:0] commit_wdata_i;

   logic                     step_req_o;
   logic [HartW-1:0]         step_hart_o;
   logic                     step_ack_i;
   logic [XLen-1:0]          ref_pc_i;
   logic                     ref_rd_we_i;
   logic [4:0]               ref_rd_i;
   logic [XLen-1:0]          ref_wdata_i;
   logic                     sim_done_i;

   logic                     mismatch_o;
   logic [1:0]               mismatch_kind_o;
   logic [HartW-1:0]         mismatch_hart_o;
   logic [31:0]              checked_cnt_o;
   logic                     halt_o;

   modport slave (
      input  commit_valid_i, commit_pc_i, commit_rd_we_i, commit_rd_i, commit_wdata_i,
      input  step_ack_i, ref_pc_i, ref_rd_we_i, ref_rd_i, ref_wdata_i, sim_done_i,
      output commit_ready_o, step_req_o, step_hart_o,
      output mismatch_o, mismatch_kind_o, mismatch_hart_o, checked_cnt_o, halt_o
   );

   modport master (
      output commit_valid_i, commit_pc_i, commit_rd_we_i, commit_rd_i, commit_wdata_i,
      output step_ack_i, ref_pc_i, ref_rd_we_i, ref_rd_i, ref_wdata_i, sim_done_i,
      input  commit_ready_o, step_req_o, step_hart_o,
      input  mismatch_o, mismatch_kind_o, mismatch_hart_o, checked_cnt_o, halt_o
   );
endinterface

// File: rtl/cosim_step_sched.sv
// Lock-step co-simulation scheduler: buffers per-hart DUT commits, steps the
// reference model one instruction at a time and compares PC / rd writeback.
module cosim_step_sched #(
   parameter int unsigned NumHarts  = 2,
   parameter int unsigned FifoDepth = 4,
   parameter int unsigned XLen      = 64
) (
   input logic               clk_i,
   input logic               rst_i,
   cosim_step_sched_if.slave bus
);
   localparam int unsigned HartW = (NumHarts > 1) ? $clog2(NumHarts) : 1;
   localparam int unsigned PtrW  = $clog2(FifoDepth);
   localparam int unsigned CntW  = PtrW + 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StStep = 2'd1;
   localparam logic [1:0] StCmp  = 2'd2;
   localparam logic [1:0] StHalt = 2'd3;

   logic [XLen-1:0] pc_mem    [NumHarts][FifoDepth];
   logic [XLen-1:0] wdata_mem [NumHarts][FifoDepth];
   logic [4:0]      rd_mem    [NumHarts][FifoDepth];
   logic            we_mem    [NumHarts][FifoDepth];

   logic [PtrW-1:0] wr_ptr [NumHarts];
   logic [PtrW-1:0] rd_ptr [NumHarts];
   logic [CntW-1:0] count  [NumHarts];

   logic [NumHarts-1:0] push, pop, nonempty, ready;

   logic [1:0]       state_q, state_d;
   logic [HartW-1:0] gnt_q, gnt_d;
   logic [HartW-1:0] rr_q, rr_d;
   logic             step_req_q, step_req_d;
   logic             mm_q, mm_d;
   logic [1:0]       kind_q, kind_d;
   logic [HartW-1:0] mm_hart_q, mm_hart_d;
   logic [31:0]      cnt_q, cnt_d;
   logic             halt_q, halt_d;
   logic             done_pend_q, done_pend_d;

   logic             found;
   logic [HartW-1:0] sel, cand;

   logic [XLen-1:0]  head_pc, head_wdata;
   logic [4:0]       head_rd;
   logic             head_we, dut_we, ref_we, pc_mm, reg_mm;

   // Per-hart accept/pop strobes; a full buffer never accepts, even while popping.
   always_comb begin
      for (int h = 0; h < int'(NumHarts); h++) begin
         nonempty[h] = (count[h] != '0);
         ready[h]    = (count[h] != CntW'(FifoDepth)) && !halt_q && !rst_i;
         push[h]     = bus.commit_valid_i[h] && ready[h];
         pop[h]      = (state_q == StCmp) && (gnt_q == HartW'(h));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int h = 0; h < int'(NumHarts); h++) begin
            wr_ptr[h] <= '0;
            rd_ptr[h] <= '0;
            count[h]  <= '0;
         end
      end else begin
         for (int h = 0; h < int'(NumHarts); h++) begin
            if (push[h]) wr_ptr[h] <= wr_ptr[h] + PtrW'(1);
            if (pop[h])  rd_ptr[h] <= rd_ptr[h] + PtrW'(1);
            if (push[h] && !pop[h])      count[h] <= count[h] + CntW'(1);
            else if (!push[h] && pop[h]) count[h] <= count[h] - CntW'(1);
         end
      end
   end

   // Entry storage carries no reset; pointers alone define validity.
   always_ff @(posedge clk_i) begin
      for (int h = 0; h < int'(NumHarts); h++) begin
         if (push[h]) begin
            pc_mem[h][wr_ptr[h]]    <= bus.commit_pc_i[h*XLen +: XLen];
            wdata_mem[h][wr_ptr[h]] <= bus.commit_wdata_i[h*XLen +: XLen];
            rd_mem[h][wr_ptr[h]]    <= bus.commit_rd_i[h*5 +: 5];
            we_mem[h][wr_ptr[h]]    <= bus.commit_rd_we_i[h];
         end
      end
   end

   // Round-robin search beginning at the hart after the last grant.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int i = 0; i < int'(NumHarts); i++) begin
         cand = HartW'((int'(rr_q) + i >= int'(NumHarts)) ?
                       (int'(rr_q) + i - int'(NumHarts)) : (int'(rr_q) + i));
         if (!found && nonempty[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   // Head of the granted hart is stable through STEP, so compare against ref_* at ack.
   always_comb begin
      head_pc    = pc_mem[gnt_q][rd_ptr[gnt_q]];
      head_wdata = wdata_mem[gnt_q][rd_ptr[gnt_q]];
      head_rd    = rd_mem[gnt_q][rd_ptr[gnt_q]];
      head_we    = we_mem[gnt_q][rd_ptr[gnt_q]];
      dut_we     = head_we && (head_rd != 5'd0);
      ref_we     = bus.ref_rd_we_i && (bus.ref_rd_i != 5'd0);
      pc_mm      = (head_pc != bus.ref_pc_i);
      reg_mm     = (dut_we != ref_we) ||
                   (dut_we && ref_we &&
                    ((head_rd != bus.ref_rd_i) || (head_wdata != bus.ref_wdata_i)));
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      rr_d        = rr_q;
      step_req_d  = step_req_q;
      mm_d        = 1'b0;
      kind_d      = 2'b00;
      mm_hart_d   = '0;
      cnt_d       = cnt_q;
      halt_d      = halt_q;
      done_pend_d = done_pend_q;
      case (state_q)
         StIdle: begin
            if (bus.sim_done_i) begin
               state_d = StHalt;
               halt_d  = 1'b1;
            end else if (found) begin
               state_d    = StStep;
               step_req_d = 1'b1;
               gnt_d      = sel;
               rr_d       = (sel == HartW'(NumHarts - 1)) ? '0 : sel + HartW'(1);
            end
         end
         StStep: begin
            if (bus.sim_done_i) done_pend_d = 1'b1;
            if (bus.step_ack_i) begin
               state_d    = StCmp;
               step_req_d = 1'b0;
               if (pc_mm || reg_mm) begin
                  mm_d      = 1'b1;
                  kind_d    = {reg_mm, pc_mm};
                  mm_hart_d = gnt_q;
               end
            end
         end
         StCmp: begin
            cnt_d       = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
            done_pend_d = 1'b0;
            if (mm_q || done_pend_q || bus.sim_done_i) begin
               state_d = StHalt;
               halt_d  = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         StHalt:  ;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         gnt_q       <= '0;
         rr_q        <= '0;
         step_req_q  <= 1'b0;
         mm_q        <= 1'b0;
         kind_q      <= 2'b00;
         mm_hart_q   <= '0;
         cnt_q       <= '0;
         halt_q      <= 1'b0;
         done_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         rr_q        <= rr_d;
         step_req_q  <= step_req_d;
         mm_q        <= mm_d;
         kind_q      <= kind_d;
         mm_hart_q   <= mm_hart_d;
         cnt_q       <= cnt_d;
         halt_q      <= halt_d;
         done_pend_q <= done_pend_d;
      end
   end

   assign bus.commit_ready_o  = ready;
   assign bus.step_req_o      = step_req_q;
   assign bus.step_hart_o     = gnt_q;
   assign bus.mismatch_o      = mm_q;
   assign bus.mismatch_kind_o = kind_q;
   assign bus.mismatch_hart_o = mm_hart_q;
   assign bus.checked_cnt_o   = cnt_q;
   assign bus.halt_o          = halt_q;
endmodule

// File: tb/tb_cosim_step_sched.sv
// Directed bench for cosim_step_sched: a compare-vector table plus hand-written
// sequences for round-robin, FIFO fill/wrap, sim_done and mid-step reset.
module tb_cosim_step_sched;
   localparam int unsigned NH = 2;
   localparam int unsigned XL = 64;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   cosim_step_sched_if #(.NumHarts(NH), .XLen(XL)) bus ();

   cosim_step_sched #(.NumHarts(NH), .FifoDepth(4), .XLen(XL)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      int          hart;
      logic [63:0] pc;
      logic        we;
      logic [4:0]  rd;
      logic [63:0] wd;
      logic [63:0] rpc;
      logic        rwe;
      logic [4:0]  rrd;
      logic [63:0] rwd;
      logic [1:0]  kind;
   } vec_t;

   vec_t vecs[9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] e_pc(input int h, input int k);
      return 64'h8000_0000 + 64'(h) * 64'h1000 + 64'(k) * 64'd4;
   endfunction
   function automatic logic [4:0] e_rd(input int h, input int k);
      return 5'(((h * 3 + k) % 31) + 1);
   endfunction
   function automatic logic [63:0] e_wd(input int h, input int k);
      return 64'hDEAD_0000 + 64'(h * 256 + k);
   endfunction

   task automatic drive_raw(input int h, input logic [63:0] pc, input logic we,
                            input logic [4:0] rd, input logic [63:0] wd);
      bus.commit_valid_i[h]          = 1'b1;
      bus.commit_pc_i[h*XL +: XL]    = pc;
      bus.commit_rd_we_i[h]          = we;
      bus.commit_rd_i[h*5 +: 5]      = rd;
      bus.commit_wdata_i[h*XL +: XL] = wd;
   endtask

   task automatic drive_entry(input int h, input int k);
      drive_raw(h, e_pc(h, k), 1'b1, e_rd(h, k), e_wd(h, k));
   endtask

   task automatic do_reset();
      bus.commit_valid_i = '0;
      bus.step_ack_i     = 1'b0;
      bus.sim_done_i     = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_req();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.step_req_o) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check("step_req_seen", 64'(ok), 64'd1);
   endtask

   // Serve one step for entry (h,k) with matching reference; optionally push during CMP.
   task automatic serve(input int h, input int k, input int delay,
                        input bit cmp_push, input int ph, input int pk);
      wait_req();
      check("serve_hart", 64'(bus.step_hart_o), 64'(h));
      for (int d = 0; d < delay; d++) begin
         tick();
         check("hold_req", 64'(bus.step_req_o), 64'd1);
         check("hold_hart", 64'(bus.step_hart_o), 64'(h));
      end
      bus.step_ack_i  = 1'b1;
      bus.ref_pc_i    = e_pc(h, k);
      bus.ref_rd_we_i = 1'b1;
      bus.ref_rd_i    = e_rd(h, k);
      bus.ref_wdata_i = e_wd(h, k);
      tick();
      bus.step_ack_i = 1'b0;
      check("serve_no_mm", 64'(bus.mismatch_o), 64'd0);
      check("serve_req_low", 64'(bus.step_req_o), 64'd0);
      if (cmp_push) begin
         drive_entry(ph, pk);
         check("cmp_push_ready", 64'(bus.commit_ready_o[ph]), 64'd1);
      end
      tick();
      bus.commit_valid_i = '0;
   endtask

   initial begin
      rst = 1'b0;
      bus.commit_valid_i = '0;
      bus.commit_pc_i    = '0;
      bus.commit_rd_we_i = '0;
      bus.commit_rd_i    = '0;
      bus.commit_wdata_i = '0;
      bus.step_ack_i     = 1'b0;
      bus.ref_pc_i       = '0;
      bus.ref_rd_we_i    = 1'b0;
      bus.ref_rd_i       = '0;
      bus.ref_wdata_i    = '0;
      bus.sim_done_i     = 1'b0;

      vecs[0] = '{0, 64'h8000_0000, 1'b1, 5'd5,  64'h1234, 64'h8000_0000, 1'b1, 5'd5,  64'h1234, 2'b00};
      vecs[1] = '{0, 64'h8000_0000, 1'b1, 5'd5,  64'h1234, 64'h8000_0004, 1'b1, 5'd5,  64'h5678, 2'b11};
      vecs[2] = '{0, 64'h8000_0000, 1'b1, 5'd0,  64'h1234, 64'h8000_0000, 1'b0, 5'd0,  64'h0,    2'b00};
      vecs[3] = '{0, 64'h8000_0010, 1'b1, 5'd7,  64'h00AA, 64'h8000_0010, 1'b1, 5'd8,  64'h00AA, 2'b10};
      vecs[4] = '{1, 64'h8000_0020, 1'b1, 5'd3,  64'h0055, 64'h8000_0024, 1'b1, 5'd3,  64'h0055, 2'b01};
      vecs[5] = '{1, 64'h8000_0030, 1'b0, 5'd3,  64'h0055, 64'h8000_0030, 1'b1, 5'd3,  64'h0055, 2'b10};
      vecs[6] = '{0, 64'h8000_0040, 1'b0, 5'd4,  64'h0011, 64'h8000_0040, 1'b0, 5'd9,  64'h0022, 2'b00};
      vecs[7] = '{1, 64'h8000_0050, 1'b0, 5'd0,  64'h0000, 64'h8000_0050, 1'b1, 5'd0,  64'h0099, 2'b00};
      vecs[8] = '{0, 64'h8000_0060, 1'b1, 5'd31, 64'hFFFF, 64'h8000_0060, 1'b1, 5'd31, 64'hFFFE, 2'b10};

      // Reset values, sampled while reset is still held
      bus.commit_valid_i = '0;
      rst = 1'b1;
      tick();
      tick();
      check("rst_ready", 64'(bus.commit_ready_o), 64'd0);
      check("rst_step_req", 64'(bus.step_req_o), 64'd0);
      check("rst_step_hart", 64'(bus.step_hart_o), 64'd0);
      check("rst_mismatch", 64'(bus.mismatch_o), 64'd0);
      check("rst_kind", 64'(bus.mismatch_kind_o), 64'd0);
      check("rst_mm_hart", 64'(bus.mismatch_hart_o), 64'd0);
      check("rst_cnt", 64'(bus.checked_cnt_o), 64'd0);
      check("rst_halt", 64'(bus.halt_o), 64'd0);
      rst = 1'b0;
      #1;
      check("ready_after_release", 64'(bus.commit_ready_o), 64'd3);

      // Table: one commit per vector, compare outcome in CMP and after it
      for (int v = 0; v < 9; v++) begin
         bit exp_mm;
         exp_mm = (vecs[v].kind != 2'b00);
         do_reset();
         drive_raw(vecs[v].hart, vecs[v].pc, vecs[v].we, vecs[v].rd, vecs[v].wd);
         tick();
         bus.commit_valid_i = '0;
         check($sformatf("v%0d_req_idle", v), 64'(bus.step_req_o), 64'd0);
         tick();
         check($sformatf("v%0d_req", v), 64'(bus.step_req_o), 64'd1);
         check($sformatf("v%0d_hart", v), 64'(bus.step_hart_o), 64'(vecs[v].hart));
         bus.step_ack_i  = 1'b1;
         bus.ref_pc_i    = vecs[v].rpc;
         bus.ref_rd_we_i = vecs[v].rwe;
         bus.ref_rd_i    = vecs[v].rrd;
         bus.ref_wdata_i = vecs[v].rwd;
         tick();
         bus.step_ack_i = 1'b0;
         check($sformatf("v%0d_mm", v), 64'(bus.mismatch_o), 64'(exp_mm));
         check($sformatf("v%0d_kind", v), 64'(bus.mismatch_kind_o), 64'(vecs[v].kind));
         check($sformatf("v%0d_mm_hart", v), 64'(bus.mismatch_hart_o),
               exp_mm ? 64'(vecs[v].hart) : 64'd0);
         check($sformatf("v%0d_req_drop", v), 64'(bus.step_req_o), 64'd0);
         tick();
         check($sformatf("v%0d_mm_pulse", v), 64'(bus.mismatch_o), 64'd0);
         check($sformatf("v%0d_cnt", v), 64'(bus.checked_cnt_o), 64'd1);
         check($sformatf("v%0d_halt", v), 64'(bus.halt_o), 64'(exp_mm));
         check($sformatf("v%0d_ready", v), 64'(bus.commit_ready_o), exp_mm ? 64'd0 : 64'd3);
      end

      // Halt is sticky: pushes and acks have no effect
      for (int i = 0; i < 3; i++) begin
         drive_entry(0, i);
         bus.step_ack_i = 1'b1;
         tick();
         check("halt_sticky", 64'(bus.halt_o), 64'd1);
         check("halt_no_req", 64'(bus.step_req_o), 64'd0);
         check("halt_cnt", 64'(bus.checked_cnt_o), 64'd1);
      end
      bus.commit_valid_i = '0;
      bus.step_ack_i     = 1'b0;

      // Round robin across two harts with a delayed ack
      do_reset();
      drive_entry(0, 0); drive_entry(1, 0);
      tick();
      drive_entry(0, 1); drive_entry(1, 1);
      tick();
      bus.commit_valid_i = '0;
      serve(0, 0, 3, 1'b0, 0, 0);
      serve(1, 0, 3, 1'b0, 0, 0);
      serve(0, 1, 3, 1'b0, 0, 0);
      serve(1, 1, 3, 1'b0, 0, 0);
      check("rr_cnt", 64'(bus.checked_cnt_o), 64'd4);
      check("rr_halt", 64'(bus.halt_o), 64'd0);

      // Fill hart1 to depth, then push during CMP and wrap the pointers
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive_entry(1, k);
         tick();
      end
      drive_entry(1, 4);
      check("full_ready", 64'(bus.commit_ready_o), 64'd1);
      tick();
      check("full_hold_ready", 64'(bus.commit_ready_o), 64'd1);
      bus.commit_valid_i = '0;
      serve(1, 0, 1, 1'b0, 0, 0);
      check("after_pop_ready", 64'(bus.commit_ready_o), 64'd3);
      serve(1, 1, 0, 1'b1, 1, 4);
      serve(1, 2, 0, 1'b1, 1, 5);
      serve(1, 3, 0, 1'b1, 1, 6);
      serve(1, 4, 0, 1'b0, 0, 0);
      serve(1, 5, 0, 1'b0, 0, 0);
      serve(1, 6, 0, 1'b0, 0, 0);
      check("wrap_cnt", 64'(bus.checked_cnt_o), 64'd7);
      check("wrap_halt", 64'(bus.halt_o), 64'd0);
      tick();
      check("wrap_empty", 64'(bus.step_req_o), 64'd0);

      // sim_done in IDLE halts immediately
      do_reset();
      bus.sim_done_i = 1'b1;
      tick();
      bus.sim_done_i = 1'b0;
      check("done_idle_halt", 64'(bus.halt_o), 64'd1);
      check("done_idle_ready", 64'(bus.commit_ready_o), 64'd0);

      // sim_done during STEP takes effect after CMP
      do_reset();
      drive_entry(0, 0);
      tick();
      bus.commit_valid_i = '0;
      wait_req();
      bus.sim_done_i = 1'b1;
      tick();
      bus.sim_done_i = 1'b0;
      check("done_step_no_halt", 64'(bus.halt_o), 64'd0);
      check("done_step_req", 64'(bus.step_req_o), 64'd1);
      serve(0, 0, 0, 1'b0, 0, 0);
      check("done_step_halt", 64'(bus.halt_o), 64'd1);
      check("done_step_cnt", 64'(bus.checked_cnt_o), 64'd1);

      // Reset while a step is outstanding; the late ack must be ignored
      do_reset();
      drive_entry(0, 0);
      tick();
      bus.commit_valid_i = '0;
      wait_req();
      rst = 1'b1;
      tick();
      check("mid_rst_req", 64'(bus.step_req_o), 64'd0);
      check("mid_rst_ready", 64'(bus.commit_ready_o), 64'd0);
      check("mid_rst_cnt", 64'(bus.checked_cnt_o), 64'd0);
      rst = 1'b0;
      #1;
      check("mid_rst_release_ready", 64'(bus.commit_ready_o), 64'd3);
      bus.step_ack_i  = 1'b1;
      bus.ref_pc_i    = e_pc(0, 0);
      bus.ref_rd_we_i = 1'b1;
      bus.ref_rd_i    = e_rd(0, 0);
      bus.ref_wdata_i = e_wd(0, 0);
      tick();
      bus.step_ack_i = 1'b0;
      tick();
      tick();
      check("late_ack_req", 64'(bus.step_req_o), 64'd0);
      check("late_ack_mm", 64'(bus.mismatch_o), 64'd0);
      check("late_ack_cnt", 64'(bus.checked_cnt_o), 64'd0);
      check("late_ack_halt", 64'(bus.halt_o), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
